// File: rtl/frv_lsu_rsp.sv
// frv_lsu_rsp: matches in-order data memory responses to granted requests,
// aligns/extends load data and hands one completion per request to writeback.
module frv_lsu_rsp #(
    parameter int DEPTH = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        req_fire,
    input  logic        req_load,
    input  logic        req_byte,
    input  logic        req_half,
    input  logic        req_word,
    input  logic        req_signed,
    input  logic [1:0]  req_off,
    input  logic        flush,
    input  logic        dmem_recv,
    output logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_error,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_rdata,
    output logic        wb_load,
    output logic        wb_error,
    output logic        trk_full,
    output logic        busy,
    output logic        rsp_spurious
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic       load;
        logic       bw;
        logic       hw;
        logic       ww;
        logic       sgn;
        logic [1:0] off;
        logic       kill;
    } ent_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   wb_rdata_q, wb_rdata_d;
    logic          wb_load_q, wb_load_d;
    logic          wb_error_q, wb_error_d;
    logic          spur_q, spur_d;

    logic          rsp_acc;
    logic          pop;
    logic          push;
    logic          cpl;
    ent_t          hd;
    ent_t          new_ent;
    logic [15:0]   sh;
    logic [31:0]   ld_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) return '0;
        return p + PW'(1);
    endfunction

    assign dmem_ack = !wb_valid_q || wb_ready;
    assign rsp_acc  = dmem_recv && dmem_ack;
    assign pop      = rsp_acc && (count_q != '0);
    assign push     = req_fire && ((count_q != FULL) || pop);
    assign hd       = ent_q[rd_ptr_q];
    assign cpl      = pop && !hd.kill && !flush;

    assign new_ent = '{load: req_load, bw: req_byte, hw: req_half,
                       ww: req_word, sgn: req_signed, off: req_off,
                       kill: flush};

    // Only the low halfword of the shifted word feeds byte/half results.
    assign sh = 16'(dmem_rdata >> {hd.off, 3'b000});

    always_comb begin
        ld_data = dmem_rdata;
        case (1'b1)
            hd.bw:   ld_data = {{24{hd.sgn & sh[7]}}, sh[7:0]};
            hd.hw:   ld_data = {{16{hd.sgn & sh[15]}}, sh};
            hd.ww:   ld_data = dmem_rdata;
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        ent_d = ent_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].kill = 1'b1;
        end
        if (push) ent_d[wr_ptr_q] = new_ent;
    end

    always_comb begin
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rdata_d = wb_rdata_q;
        wb_load_d  = wb_load_q;
        wb_error_d = wb_error_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (cpl) begin
            wb_valid_d = 1'b1;
            wb_load_d  = hd.load;
            wb_error_d = dmem_error;
            wb_rdata_d = (hd.load && !dmem_error) ? ld_data : '0;
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end
        spur_d = rsp_acc && (count_q == '0) && !req_fire;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rdata_q <= '0;
            wb_load_q  <= 1'b0;
            wb_error_q <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_rdata_q <= wb_rdata_d;
            wb_load_q  <= wb_load_d;
            wb_error_q <= wb_error_d;
            spur_q     <= spur_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rdata     = wb_rdata_q;
    assign wb_load      = wb_load_q;
    assign wb_error     = wb_error_q;
    assign trk_full     = (count_q == FULL);
    assign busy         = (count_q != '0) || wb_valid_q;
    assign rsp_spurious = spur_q;

endmodule

// File: tb/tb_frv_lsu_rsp.sv
// Directed bench for frv_lsu_rsp: alignment, backpressure, tracker,
// flush, error, spurious response and reset.
module tb_frv_lsu_rsp;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        req_fire = 1'b0;
    logic        req_load = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_half = 1'b0;
    logic        req_word = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_off = 2'd0;
    logic        flush = 1'b0;
    logic        dmem_recv = 1'b0;
    logic        dmem_ack;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_error = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_rdata;
    logic        wb_load;
    logic        wb_error;
    logic        trk_full;
    logic        busy;
    logic        rsp_spurious;

    int vec = 0;
    int errs = 0;

    frv_lsu_rsp #(.DEPTH(2)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_fire(req_fire), .req_load(req_load),
        .req_byte(req_byte), .req_half(req_half),
        .req_word(req_word), .req_signed(req_signed),
        .req_off(req_off), .flush(flush),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rdata(wb_rdata), .wb_load(wb_load),
        .wb_error(wb_error), .trk_full(trk_full),
        .busy(busy), .rsp_spurious(rsp_spurious)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_req(input logic ld, input logic bw, input logic hw,
                           input logic ww, input logic sg, input logic [1:0] off);
        req_fire = 1'b1; req_load = ld; req_byte = bw; req_half = hw;
        req_word = ww; req_signed = sg; req_off = off;
    endtask

    task automatic fire(input logic ld, input logic bw, input logic hw,
                        input logic ww, input logic sg, input logic [1:0] off);
        set_req(ld, bw, hw, ww, sg, off);
        tick;
        req_fire = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d, input logic e);
        dmem_recv = 1'b1; dmem_rdata = d; dmem_error = e;
        tick;
        dmem_recv = 1'b0; dmem_error = 1'b0;
    endtask

    task automatic test_reset;
        g_resetn = 1'b0;
        tick; tick;
        g_resetn = 1'b1;
        tick;
        vec++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", wb_valid); end
        vec++; if (wb_rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h exp 0", wb_rdata); end
        vec++; if ({wb_load, wb_error, rsp_spurious} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b exp 000", {wb_load, wb_error, rsp_spurious}); end
        vec++; if ({trk_full, busy, dmem_ack} !== 3'b001) begin errs++; $display("FAIL rst_status got %b exp 001", {trk_full, busy, dmem_ack}); end
    endtask

    task automatic test_load(input string nm, input logic bw, input logic hw,
                             input logic ww, input logic sg, input logic [1:0] off,
                             input logic [31:0] d, input logic [31:0] exp);
        fire(1'b1, bw, hw, ww, sg, off);
        vec++; if ({wb_valid, busy} !== 2'b01) begin errs++; $display("FAIL %s pre got v/b %b exp 01", nm, {wb_valid, busy}); end
        resp(d, 1'b0);
        vec++; if (wb_valid !== 1'b1) begin errs++; $display("FAIL %s valid got %b exp 1", nm, wb_valid); end
        vec++; if (wb_rdata !== exp) begin errs++; $display("FAIL %s data got %h exp %h", nm, wb_rdata, exp); end
        vec++; if ({wb_load, wb_error} !== 2'b10) begin errs++; $display("FAIL %s flags got %b exp 10", nm, {wb_load, wb_error}); end
        tick;
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL %s post got v/b %b exp 00", nm, {wb_valid, busy}); end
    endtask

    task automatic test_backpressure;
        wb_ready = 1'b0;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'h1111_1111, 1'b0);
        vec++; if (wb_rdata !== 32'h1111_1111) begin errs++; $display("FAIL bp_first got %h exp 11111111", wb_rdata); end
        dmem_recv = 1'b1; dmem_rdata = 32'h2222_2222;
        #1;
        vec++; if (dmem_ack !== 1'b0) begin errs++; $display("FAIL bp_ack_low got %b exp 0", dmem_ack); end
        tick;
        vec++; if ({wb_valid, wb_rdata} !== {1'b1, 32'h1111_1111}) begin errs++; $display("FAIL bp_hold got %b/%h exp 1/11111111", wb_valid, wb_rdata); end
        wb_ready = 1'b1;
        #1;
        vec++; if (dmem_ack !== 1'b1) begin errs++; $display("FAIL bp_ack_high got %b exp 1", dmem_ack); end
        tick;
        dmem_recv = 1'b0;
        vec++; if ({wb_valid, wb_rdata} !== {1'b1, 32'h2222_2222}) begin errs++; $display("FAIL bp_second got %b/%h exp 1/22222222", wb_valid, wb_rdata); end
        tick;
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL bp_drain got %b exp 00", {wb_valid, busy}); end
    endtask

    task automatic test_full;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        vec++; if (trk_full !== 1'b0) begin errs++; $display("FAIL full_one got %b exp 0", trk_full); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        vec++; if (trk_full !== 1'b1) begin errs++; $display("FAIL full_two got %b exp 1", trk_full); end
        set_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        dmem_recv = 1'b1; dmem_rdata = 32'hAAAA_0001;
        tick;
        req_fire = 1'b0; dmem_recv = 1'b0;
        vec++; if (trk_full !== 1'b1) begin errs++; $display("FAIL full_pushpop got %b exp 1", trk_full); end
        vec++; if ({wb_valid, wb_rdata} !== {1'b1, 32'hAAAA_0001}) begin errs++; $display("FAIL full_cplA got %b/%h exp 1/aaaa0001", wb_valid, wb_rdata); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        vec++; if (trk_full !== 1'b1) begin errs++; $display("FAIL full_drop got %b exp 1", trk_full); end
        resp(32'hBBBB_0002, 1'b0);
        vec++; if ({trk_full, wb_rdata} !== {1'b0, 32'hBBBB_0002}) begin errs++; $display("FAIL full_cplB got %b/%h exp 0/bbbb0002", trk_full, wb_rdata); end
        resp(32'hCCCC_0003, 1'b0);
        vec++; if ({wb_valid, wb_rdata} !== {1'b1, 32'hCCCC_0003}) begin errs++; $display("FAIL full_cplC got %b/%h exp 1/cccc0003", wb_valid, wb_rdata); end
        resp(32'hDDDD_0004, 1'b0);
        vec++; if ({rsp_spurious, wb_valid, busy} !== 3'b100) begin errs++; $display("FAIL full_dropped_push got %b exp 100", {rsp_spurious, wb_valid, busy}); end
        tick;
    endtask

    task automatic test_flush;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        flush = 1'b1; tick; flush = 1'b0;
        vec++; if ({wb_valid, busy, trk_full} !== 3'b011) begin errs++; $display("FAIL fl_after got %b exp 011", {wb_valid, busy, trk_full}); end
        resp(32'h1234_5678, 1'b0);
        vec++; if ({wb_valid, busy} !== 2'b01) begin errs++; $display("FAIL fl_rsp1 got %b exp 01", {wb_valid, busy}); end
        resp(32'h1234_5678, 1'b0);
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL fl_rsp2 got %b exp 00", {wb_valid, busy}); end
        set_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        flush = 1'b1; tick; flush = 1'b0; req_fire = 1'b0;
        resp(32'h5555_5555, 1'b0);
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL fl_samecyc got %b exp 00", {wb_valid, busy}); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        dmem_recv = 1'b1; dmem_rdata = 32'h6666_6666; flush = 1'b1;
        tick;
        dmem_recv = 1'b0; flush = 1'b0;
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL fl_popcyc got %b exp 00", {wb_valid, busy}); end
        wb_ready = 1'b0;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'h7777_7777, 1'b0);
        flush = 1'b1; tick; flush = 1'b0;
        wb_ready = 1'b1;
        vec++; if ({wb_valid, busy} !== 2'b00) begin errs++; $display("FAIL fl_wbclr got %b exp 00", {wb_valid, busy}); end
    endtask

    task automatic test_err_spur;
        fire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'hFFFF_FFFF, 1'b1);
        vec++; if ({wb_valid, wb_load, wb_error} !== 3'b101) begin errs++; $display("FAIL err_st_flags got %b exp 101", {wb_valid, wb_load, wb_error}); end
        vec++; if (wb_rdata !== 32'h0) begin errs++; $display("FAIL err_st_data got %h exp 0", wb_rdata); end
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'hDEAD_BEEF, 1'b1);
        vec++; if ({wb_valid, wb_load, wb_error, wb_rdata} !== {3'b111, 32'h0}) begin errs++; $display("FAIL err_ld got %b/%h exp 111/0", {wb_valid, wb_load, wb_error}, wb_rdata); end
        fire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'hFFFF_FFFF, 1'b0);
        vec++; if ({wb_valid, wb_load, wb_error, wb_rdata} !== {3'b100, 32'h0}) begin errs++; $display("FAIL store_ok got %b/%h exp 100/0", {wb_valid, wb_load, wb_error}, wb_rdata); end
        tick;
        resp(32'h1357_9BDF, 1'b0);
        vec++; if ({rsp_spurious, wb_valid, busy} !== 3'b100) begin errs++; $display("FAIL spur_pulse got %b exp 100", {rsp_spurious, wb_valid, busy}); end
        tick;
        vec++; if (rsp_spurious !== 1'b0) begin errs++; $display("FAIL spur_clear got %b exp 0", rsp_spurious); end
    endtask

    task automatic test_reset_mid;
        wb_ready = 1'b0;
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        fire(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        resp(32'hCAFE_F00D, 1'b0);
        vec++; if ({wb_valid, busy, wb_load} !== 3'b111) begin errs++; $display("FAIL rm_pre got %b exp 111", {wb_valid, busy, wb_load}); end
        g_resetn = 1'b0; tick; g_resetn = 1'b1;
        wb_ready = 1'b1;
        vec++; if ({wb_valid, busy, trk_full, wb_load, wb_error} !== 5'b0) begin errs++; $display("FAIL rm_flags got %b exp 00000", {wb_valid, busy, trk_full, wb_load, wb_error}); end
        vec++; if (wb_rdata !== 32'h0) begin errs++; $display("FAIL rm_data got %h exp 0", wb_rdata); end
        resp(32'h0BAD_0BAD, 1'b0);
        vec++; if ({rsp_spurious, wb_valid} !== 2'b10) begin errs++; $display("FAIL rm_spur got %b exp 10", {rsp_spurious, wb_valid}); end
        tick;
    endtask

    initial begin
        test_reset;
        test_load("sbyte_off2", 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
        test_load("uhalf_off2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h8001_1234, 32'h0000_8001);
        test_load("sword", 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_load("shalf_off0", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
        test_load("ubyte_off3", 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'hAB00_0000, 32'h0000_00AB);
        test_load("sbyte_off1_pos", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'hFFFF_7FFF, 32'h0000_007F);
        test_backpressure;
        test_full;
        test_flush;
        test_err_spur;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/frv_lsu_rsp.md
Name: frv_lsu_rsp

Overview:
Load/store response unit sitting directly downstream of the load store unit on the data memory bus. Records the attributes of every granted data request and matches in-order memory responses against them. Aligns and sign/zero-extends load data, then presents one completion per request to the writeback stage over a valid/ready handshake. Also tracks outstanding transactions so the core can hold new requests (hold_lsu_req) when the tracker is full.

Parameters:
DEPTH, 2, maximum outstanding granted requests; power of two, minimum 1.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  synchronous active-low reset
req_fire  input  1  data request granted this cycle (dmem_req && dmem_gnt)
req_load  input  1  granted request is a load
req_byte  input  1  byte width
req_half  input  1  halfword width
req_word  input  1  word width
req_signed  input  1  sign-extend loaded data
req_off  input  2  lsu_addr[1:0] of granted request
flush  input  1  pipeline flush; kill all outstanding completions
dmem_recv  input  1  memory response valid
dmem_ack  output  1  response accepted
dmem_rdata  input  32  response read data (word aligned)
dmem_error  input  1  response bus error
wb_valid  output  1  completion valid
wb_ready  input  1  writeback consumes completion
wb_rdata  output  32  aligned/extended load data; 0 for stores
wb_load  output  1  completion belongs to a load
wb_error  output  1  completion carries bus error
trk_full  output  1  DEPTH requests outstanding; drive into hold_lsu_req
busy  output  1  any request outstanding or wb_valid high
rsp_spurious  output  1  one-cycle pulse: response with no outstanding request

Behaviour:
- Reset (g_resetn low at a g_clk edge): tracker empty, pointers/count 0, all kill bits 0, wb_valid 0, wb_rdata 0, wb_load 0, wb_error 0, rsp_spurious 0. trk_full 0, busy 0, dmem_ack 1 after reset. Reset mid-transaction discards everything; responses arriving afterwards are spurious.
- Tracker: circular FIFO of DEPTH entries {load, byte, half, word, signed, off, kill}. Push on req_fire; pop on dmem_recv && dmem_ack when count>0. Push and pop in the same cycle are both permitted, including when full; count is unchanged.
- trk_full = (count == DEPTH), combinational from registers. req_fire while full and no pop is a protocol violation: the push is dropped and the count does not change.
- Output register: one entry. dmem_ack = !wb_valid || wb_ready. A response is accepted only when dmem_ack is high.
- On an accepted response matched to a non-killed entry, at the next edge: wb_valid=1, wb_load=entry.load, wb_error=dmem_error. Latency from response to completion is 1 cycle.
- If the accepted response matches a killed entry: pop the entry, and wb_valid is not set by that response.
- wb_valid clears on wb_valid && wb_ready unless a new completion loads in the same cycle (back-to-back throughput: 1 per cycle).
- Data for loads: shifted = dmem_rdata >> (8*off).
  - byte: {24{signed & shifted[7]}, shifted[7:0]}.
  - half: {16{signed & shifted[15]}, shifted[15:0]}.
  - word: dmem_rdata.
- Data for stores: wb_rdata = 0.
- On error: wb_rdata = 0 regardless of load/store.
- Flush: at the edge, set the kill bit on every valid tracker entry and clear wb_valid. A request pushed in the same cycle as flush is also killed. A response popped in the flush cycle produces no completion.
- Spurious response: dmem_recv && dmem_ack with count==0 (and no push that cycle) is consumed. It does not affect state except raising rsp_spurious for 1 cycle (registered).
- busy = (count != 0) || wb_valid.

Test Plan:
- Signed byte load: req_off=2, req_byte, req_signed; rdata=32'h0080_0000 -> wb_rdata=32'hFFFF_FF80, wb_load=1, wb_valid exactly 1 cycle after dmem_recv.
- Unsigned halfword: off=2, rdata=32'h8001_1234 -> wb_rdata=32'h0000_8001. Signed word: rdata=32'hDEAD_BEEF -> 32'hDEAD_BEEF unchanged.
- Backpressure: two loads outstanding, wb_ready=0 -> first completion holds and dmem_ack=0, so the second response stalls. Then wb_ready=1 -> completions on consecutive cycles in request order.
- Full tracker (DEPTH=2): two req_fire with no response -> trk_full=1. A response pop and a req_fire in the same cycle -> count stays 2 and trk_full stays 1.
- Flush with 2 outstanding: assert flush, then return 2 responses -> both acked, wb_valid stays 0, busy falls to 0 after the second response.
- Error and spurious: store response with dmem_error=1 -> wb_error=1, wb_rdata=0, wb_load=0. Response with empty tracker -> rsp_spurious pulses 1 cycle and no wb_valid. Reset asserted with 1 outstanding -> all outputs return to reset values next edge.
